// File: rtl/hack_alu_pipe.sv
// hack_alu_pipe: two-stage pipelined Hack ALU with an accumulator operand.
// S1 conditions the operands and runs the add/and core.
// S2 applies the output negate and derives the result flags.
// A ready/valid handshake on both sides lets backpressure stall the whole pipe.
// An interlock holds acc_sel operations until the pipe is empty, so they
// always read the most recently consumed result.
module hack_alu_pipe #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [5:0]       ctrl,
    input  logic             acc_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] o,
    output logic             zr,
    output logic             ng,
    output logic             cy,
    output logic             ov,
    output logic [WIDTH-1:0] acc
);

    // S1 state
    logic             s1_valid_reg;
    logic [WIDTH-1:0] s1_r_reg;
    logic             s1_cy_reg;
    logic             s1_ov_reg;
    logic             s1_no_reg;

    // S2 state (the presented result)
    logic             out_valid_reg;
    logic [WIDTH-1:0] o_reg;
    logic             zr_reg;
    logic             ng_reg;
    logic             cy_reg;
    logic             ov_reg;

    // Accumulator: the last result taken by the consumer
    logic [WIDTH-1:0] acc_reg;

    // Handshake and pipeline control
    logic en;
    logic accept;
    logic out_hs;

    // Operand datapath: index 0 is the X side, index 1 is the Y side
    logic [WIDTH-1:0] opnd_raw [2];
    logic [WIDTH-1:0] opnd_n   [2];

    // Core results feeding S1
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH-1:0] r_next;
    logic             cy_next;
    logic             ov_next;

    // S2 result before registering
    logic [WIDTH-1:0] o_next;

    assign en       = !out_valid_reg || out_ready;
    // The acc_sel interlock waits until no older result is still pending.
    // Such a result would change acc after this operation had already read it.
    assign in_ready = !rst && en && !(acc_sel && (s1_valid_reg || out_valid_reg));
    assign accept   = in_valid && in_ready;
    assign out_hs   = out_valid_reg && out_ready;

    assign opnd_raw[0] = acc_sel ? acc_reg : x;
    assign opnd_raw[1] = y;

    // Zero/negate conditioning for each operand.
    // X uses ctrl[5:4] (zx,nx) and Y uses ctrl[3:2] (zy,ny).
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_opnd
            logic [WIDTH-1:0] opnd_z;
            assign opnd_z     = ctrl[5 - 2*gi] ? '0 : opnd_raw[gi];
            assign opnd_n[gi] = ctrl[4 - 2*gi] ? ~opnd_z : opnd_z;
        end
    endgenerate

    // Function core.
    // Carry and overflow belong to the add only, so they are forced low
    // for the AND function.
    assign sum_ext = {1'b0, opnd_n[0]} + {1'b0, opnd_n[1]};
    assign r_next  = ctrl[1] ? sum_ext[WIDTH-1:0] : (opnd_n[0] & opnd_n[1]);
    assign cy_next = ctrl[1] & sum_ext[WIDTH];
    assign ov_next = ctrl[1]
                   & (opnd_n[0][WIDTH-1] == opnd_n[1][WIDTH-1])
                   & (sum_ext[WIDTH-1] != opnd_n[0][WIDTH-1]);

    assign o_next = s1_no_reg ? ~s1_r_reg : s1_r_reg;

    // S1 register: capture an accepted operation, or take a bubble when the pipe advances
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
            s1_r_reg     <= '0;
            s1_cy_reg    <= 1'b0;
            s1_ov_reg    <= 1'b0;
            s1_no_reg    <= 1'b0;
        end else if (en) begin
            s1_valid_reg <= accept;
            if (accept) begin
                s1_r_reg  <= r_next;
                s1_cy_reg <= cy_next;
                s1_ov_reg <= ov_next;
                s1_no_reg <= ctrl[0];
            end
        end
    end

    // S2 register: advance S1 into the output; result fields only change when S1 carries an op
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            o_reg         <= '0;
            zr_reg        <= 1'b0;
            ng_reg        <= 1'b0;
            cy_reg        <= 1'b0;
            ov_reg        <= 1'b0;
        end else if (en) begin
            out_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                o_reg  <= o_next;
                zr_reg <= (o_next == '0);
                ng_reg <= o_next[WIDTH-1];
                cy_reg <= s1_cy_reg;
                ov_reg <= s1_ov_reg;
            end
        end
    end

    // Accumulator: load the presented result whenever the consumer takes it
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_reg <= '0;
        end else if (out_hs) begin
            acc_reg <= o_reg;
        end
    end

    assign out_valid = out_valid_reg;
    assign o         = o_reg;
    assign zr        = zr_reg;
    assign ng        = ng_reg;
    assign cy        = cy_reg;
    assign ov        = ov_reg;
    assign acc       = acc_reg;

endmodule

// File: tb/tb_hack_alu_pipe.sv
// tb_hack_alu_pipe: directed cases plus randomized traffic.
// A queue-based reference model checks every output cycle.
module tb_hack_alu_pipe;

    typedef struct packed {
        logic [15:0] o;
        logic        zr;
        logic        ng;
        logic        cy;
        logic        ov;
    } res_t;

    typedef struct {
        res_t r;
        int   acc_cyc;
    } entry_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] x = '0;
    logic [15:0] y = '0;
    logic [5:0]  ctrl = '0;
    logic        acc_sel = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] o;
    logic        zr, ng, cy, ov;
    logic [15:0] acc;

    int checks = 0;
    int errors = 0;
    int cycle = 0;
    int last_acc = 0;
    int last_pop = -100;
    logic [15:0] model_acc = '0;
    entry_t q[$];

    hack_alu_pipe #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y), .ctrl(ctrl), .acc_sel(acc_sel),
        .out_valid(out_valid), .out_ready(out_ready),
        .o(o), .zr(zr), .ng(ng), .cy(cy), .ov(ov), .acc(acc)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog cycle=%0d actual=running required=finished", cycle);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cycle, act, exp);
        end
    endtask

    // Reference ALU computed from the Hack rules.
    // Signed overflow is judged by doing the add in a wider signed integer.
    function automatic res_t ref_alu(input logic [15:0] xs, input logic [15:0] ys, input logic [5:0] c);
        logic [15:0] a, b, raw;
        int          ua, ub, sa, sb, ssum;
        res_t        r;
        a = c[5] ? 16'h0 : xs;
        if (c[4]) a = ~a;
        b = c[3] ? 16'h0 : ys;
        if (c[2]) b = ~b;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        ssum = sa + sb;
        raw = c[1] ? 16'((ua + ub) % 65536) : (a & b);
        r.o  = c[0] ? ~raw : raw;
        r.zr = (r.o == 16'h0);
        r.ng = r.o[15];
        r.cy = c[1] && (ua + ub >= 65536);
        r.ov = c[1] && (ssum > 32767 || ssum < -32768);
        return r;
    endfunction

    // Per-cycle compare: outputs against the model, then advance the model with this cycle's handshakes
    always @(negedge clk) begin
        if (cycle >= 1) begin
            logic exp_ov, exp_ir;
            int   avail;
            exp_ov = 1'b0;
            if (q.size() > 0) begin
                avail = q[0].acc_cyc + 2;
                if (last_pop + 1 > avail) avail = last_pop + 1;
                exp_ov = (cycle >= avail);
            end
            chk("out_valid", 64'(out_valid), 64'(exp_ov));
            if (exp_ov && out_valid)
                chk("result", 64'({o, zr, ng, cy, ov}), 64'(q[0].r));
            chk("acc", 64'(acc), 64'(model_acc));
            exp_ir = !rst && (!exp_ov || out_ready) && !(acc_sel && q.size() > 0);
            chk("in_ready", 64'(in_ready), 64'(exp_ir));
            if (rst) begin
                q.delete();
                model_acc = '0;
                last_pop = cycle;
            end else begin
                if (in_valid && in_ready) begin
                    entry_t e;
                    e.r = ref_alu(acc_sel ? model_acc : x, y, ctrl);
                    e.acc_cyc = cycle;
                    q.push_back(e);
                end
                if (out_valid && out_ready && exp_ov) begin
                    model_acc = q[0].r.o;
                    void'(q.pop_front());
                    last_pop = cycle;
                end
            end
        end
    end

    // Present one operation and hold it until accepted; returns cycles spent refused
    task automatic send(input logic [15:0] xv, input logic [15:0] yv, input logic [5:0] c,
                        input logic a, output int waits);
        waits = 0;
        in_valid = 1'b1; x = xv; y = yv; ctrl = c; acc_sel = a;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waits++;
            if (waits > 100) begin
                chk("send_timeout", 64'(0), 64'(1));
                break;
            end
        end
        last_acc = cycle;
        @(posedge clk); #1;
        in_valid = 1'b0; acc_sel = 1'b0;
    endtask

    // Wait for the next presented result and compare it with literal values
    task automatic expect_out(input string name, input logic [15:0] eo, input logic [3:0] ef,
                              input bit lat);
        int n = 0;
        forever begin
            @(negedge clk);
            if (out_valid) break;
            n++;
            if (n > 50) begin
                chk({name, "_timeout"}, 64'(0), 64'(1));
                return;
            end
        end
        chk(name, 64'(o), 64'(eo));
        chk({name, "_flags"}, 64'({zr, ng, cy, ov}), 64'(ef));
        if (lat) chk({name, "_latency"}, 64'(cycle - last_acc), 64'(2));
        @(posedge clk); #1;
    endtask

    localparam logic [5:0] OP_ADD  = 6'b000010;
    localparam logic [5:0] OP_YMX  = 6'b000111;
    localparam logic [5:0] OP_ONE  = 6'b111111;
    localparam logic [5:0] OP_OR   = 6'b010101;
    localparam logic [5:0] OP_XP1  = 6'b011111;

    initial begin
        int   w;
        res_t m;

        // Pin the model with hand-worked values
        m = ref_alu(16'd16, 16'd15, OP_ADD);
        chk("model_add", 64'(m), 64'({16'd31, 4'b0000}));
        m = ref_alu(16'h7FFF, 16'd1, OP_ADD);
        chk("model_ovf", 64'(m), 64'({16'h8000, 4'b0101}));
        m = ref_alu(16'd16, 16'd15, OP_ONE);
        chk("model_one", 64'(m), 64'({16'd1, 4'b0010}));
        m = ref_alu(16'd1826, 16'd1475, OP_OR);
        chk("model_or", 64'(m), 64'({16'd2019, 4'b0000}));

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_state", 64'({out_valid, o, zr, ng, cy, ov, acc}), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 64'(in_ready), 64'(1));
        @(posedge clk); #1;

        // Basic function and boundary cases
        send(16'd16, 16'd15, OP_ADD, 1'b0, w);
        expect_out("x_plus_y", 16'd31, 4'b0000, 1'b1);
        send(16'd16, 16'd15, OP_YMX, 1'b0, w);
        expect_out("y_minus_x", 16'hFFFF, 4'b0110, 1'b1);
        send(16'd16, 16'd15, OP_ONE, 1'b0, w);
        expect_out("const_one", 16'd1, 4'b0010, 1'b1);
        send(16'd1826, 16'd1475, OP_OR, 1'b0, w);
        expect_out("x_or_y", 16'd2019, 4'b0000, 1'b1);   // 0x722 | 0x5C3 = 0x7E3
        send(16'h7FFF, 16'd1, OP_ADD, 1'b0, w);
        expect_out("sgn_ovf", 16'h8000, 4'b0101, 1'b1);
        send(16'hFFFF, 16'd1, OP_ADD, 1'b0, w);
        expect_out("wrap_zero", 16'h0000, 4'b1010, 1'b1);

        // Backpressure: two ops queue up, output frozen for three cycles
        out_ready = 1'b0;
        send(16'd1, 16'd2, OP_ADD, 1'b0, w);
        send(16'd10, 16'd20, OP_ADD, 1'b0, w);
        repeat (3) begin
            @(negedge clk);
            chk("stall_valid", 64'(out_valid), 64'(1));
            chk("stall_o", 64'(o), 64'(3));
            chk("stall_in_ready", 64'(in_ready), 64'(0));
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        expect_out("drain_a", 16'd3, 4'b0000, 1'b0);
        expect_out("drain_b", 16'd30, 4'b0000, 1'b0);
        send(16'd5, 16'd6, OP_ADD, 1'b0, w);
        expect_out("drain_c", 16'd11, 4'b0000, 1'b1);

        // Accumulator interlock: acc_sel waits for the 5 to be consumed
        send(16'd5, 16'd0, OP_ADD, 1'b0, w);
        send(16'd0, 16'd0, OP_XP1, 1'b1, w);
        chk("interlock_waits", 64'(w), 64'(2));
        expect_out("acc_plus_one", 16'd6, 4'b0010, 1'b1);
        chk("acc_loaded", 64'(acc), 64'(6));

        // Reset with two operations in flight
        send(16'd100, 16'd1, OP_ADD, 1'b0, w);
        send(16'd200, 16'd1, OP_ADD, 1'b0, w);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("flush_valid", 64'(out_valid), 64'(0));
        chk("flush_acc", 64'(acc), 64'(0));
        repeat (5) begin
            @(negedge clk);
            chk("no_stale", 64'(out_valid), 64'(0));
        end
        @(posedge clk); #1;

        // Randomized traffic with backpressure, accumulator use and occasional reset
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            x         = 16'($urandom);
            y         = 16'($urandom);
            ctrl      = 6'($urandom);
            acc_sel   = ($urandom_range(0, 3) == 0);
            out_ready = ($urandom_range(0, 9) < 7);
            rst       = ($urandom_range(0, 99) == 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0; acc_sel = 1'b0; out_ready = 1'b1; rst = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("final_empty", 64'(q.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
